fp32_accum_seq: RTL and testbench
=================================

Name: fp32_accum_seq

Overview:
- Upstream issue/accumulate sequencer for the 2-cycle FP32 adder core (ACT/TAGi/A/B in; RDY/TAGo/R out).
- Accepts a stream of FP32 words from a valid/ready source and reduces them serially into one FP32 sum.
- Each element is issued to the adder with the running sum as A and the element as B. The block waits for the tagged result, then emits the final sum after the element flagged LAST.
- Tags discard stale adder results after ABORT.

Parameters:
- ADD_LAT, 2, cycles from ACT high to matching RDY high in the adder; used only by the watchdog bound.
- WD_CYCLES, 15, cycles in WAIT without a matching RDY before the ERR pulse (must be > ADD_LAT).
- CNT_W, 16, width of the element counter.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous active-high reset.
- DVAL  in  1  input element valid.
- DIN  in  32  FP32 input element.
- DLAST  in  1  element is the last of the vector.
- DRDY  out  1  block accepts DIN this cycle (DVAL&DRDY = accept).
- ABORT  in  1  drop the current vector and any in-flight result.
- ADD_ACT  out  1  adder ACT.
- ADD_TAG  out  1  adder TAGi.
- ADD_A  out  32  adder operand A (running sum).
- ADD_B  out  32  adder operand B (element).
- ADD_RDY  in  1  adder RDY.
- ADD_TAGO  in  1  adder TAGo.
- ADD_R  in  32  adder result.
- SUM  out  32  final sum, held until next SVAL.
- SVAL  out  1  one-cycle pulse: SUM and CNT valid.
- CNT  out  CNT_W  number of elements in the vector (saturating).
- ERR  out  1  one-cycle pulse: watchdog expired.
- BUSY  out  1  state != IDLE.

Behaviour:
- Interface: one clock CLK; RESET is synchronous and active-high.
- Reset values: state IDLE; acc=32'h0; SUM=0, SVAL=0, CNT=0, cnt=0, ERR=0, ADD_ACT=0, ADD_TAG=0, expected tag etag=0, wd=0, last_f=0. DRDY=0 while RESET is high.
- ADD_A, ADD_B and ADD_TAG are registered and change only on the issue cycle.
- States:
  - IDLE: DRDY=1. On accept: ADD_A<=acc (+0.0 for the first element), ADD_B<=DIN, ADD_TAG<=etag, ADD_ACT<=1 for exactly one cycle, last_f<=DLAST, cnt<=cnt+1 (saturating at all-ones). Go to WAIT.
  - WAIT: DRDY=0, wd increments.
    - On ADD_RDY & (ADD_TAGO==etag): acc<=ADD_R, etag<=~etag, wd<=0.
    - If last_f: SUM<=ADD_R, CNT<=cnt, SVAL<=1 next cycle, acc<=0, cnt<=0. Go to IDLE.
    - Otherwise go to IDLE.
    - ADD_RDY with a tag mismatch is ignored.
- Latency and throughput:
  - Adder completes in 2 cycles, so one element is accepted per 4 cycles: accept, ACT, RDY, return to IDLE.
  - SVAL is asserted 4 cycles after the LAST element is accepted.
- Watchdog: wd==WD_CYCLES in WAIT gives an ERR pulse, the same effect as ABORT, and a return to IDLE. wd clears on IDLE.
- ABORT (any state, RESET not active):
  - acc<=0, cnt<=0, last_f<=0, etag<=~etag, wd<=0, state IDLE, no SVAL.
  - ABORT has priority over a same-cycle accept (DRDY forced 0) and over a same-cycle matching RDY (result discarded).
  - Because etag flips, a result still in flight returns with the old tag and is dropped.
- RESET mid-operation: identical to reset values. The adder shares RESET, so no stale result returns.
- Single-element vector: DLAST on the first element gives SUM = +0.0 + x (adder's result for x), CNT=1.
- Special values (NaN/Inf/zero) are passed through untouched. Arithmetic is entirely the adder's.
- cnt saturates at 2^CNT_W-1 and does not wrap.
- SVAL and ERR are never high in the same cycle.

Decomposition:
- Shared package fp_seq_pkg:
  - state enum {IDLE, WAIT} as logic [0:0].
  - localparam FP32_PZERO=32'h0000_0000.
  - FP32 field typedef (sign, exp[7:0], man[22:0]).
- One sub-module is natural: fp32_accum_wd (watchdog counter with clear/enable/expire). Everything else is inline.
- Top-level bench instantiates fp32_accum_seq together with the existing FP32 adder core.

Test Plan:
- 4-element vector 1.0, 2.0, 3.0, 4.0 (3F800000, 40000000, 40400000, 40800000), DLAST on the 4th → SVAL once, SUM=41200000 (10.0), CNT=4. SVAL comes 4 cycles after the last accept; DRDY low 3 of every 4 cycles.
- Single element DIN=C0A00000 (-5.0) with DLAST → SUM=C0A00000, CNT=1, ADD_A=00000000 on the issue cycle.
- ABORT asserted the cycle after ADD_ACT for element 2 of a vector, then new vector 1.0 (DLAST):
  - the in-flight RDY with the old tag is ignored;
  - SUM=3F800000, CNT=1;
  - no SVAL for the aborted vector.
- Adder model that never returns RDY → ERR pulses exactly WD_CYCLES cycles after entering WAIT, BUSY drops next cycle, then a normal vector completes correctly.
- RESET for 1 cycle mid-WAIT → all outputs at reset values the next cycle; DRDY=1 the following cycle.
- Inputs 7F800000 (+Inf) then 3F800000 with DLAST → SUM=7F800000, CNT=2.

Source files
------------

// File: rtl/fp_seq_pkg.sv
// Shared types and constants for the FP32 accumulate sequencer.
package fp_seq_pkg;

    localparam int unsigned FP32_W     = 32;
    localparam logic [31:0] FP32_PZERO = 32'h0000_0000;

    // IEEE-754 single-precision field view
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp32_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/fp32_accum_wd.sv
// Watchdog counter: counts enabled cycles, flags one cycle before and at LIMIT.
module fp32_accum_wd #(
    parameter int unsigned LIMIT = 15
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_pre_c,
    output logic o_expire_c
);

    localparam int unsigned WD_W = $clog2(LIMIT + 1);

    logic [WD_W-1:0] r_wd;

    // Count enabled cycles; holds at LIMIT until cleared
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_wd <= '0;
        end else if (i_en && (r_wd != WD_W'(LIMIT))) begin
            r_wd <= r_wd + WD_W'(1);
        end
    end

    assign o_pre_c    = (r_wd == WD_W'(LIMIT - 1));
    assign o_expire_c = (r_wd == WD_W'(LIMIT));

endmodule

// File: rtl/fp32_accum_seq.sv
// Serial FP32 reduction sequencer driving a tagged 2-cycle adder core.
module fp32_accum_seq
    import fp_seq_pkg::*;
#(
    parameter int unsigned ADD_LAT   = 2,
    parameter int unsigned WD_CYCLES = 15,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_dval,
    input  logic [FP32_W-1:0] i_din,
    input  logic              i_dlast,
    output logic              o_drdy,
    input  logic              i_abort,
    output logic              o_add_act,
    output logic              o_add_tag,
    output logic [FP32_W-1:0] o_add_a,
    output logic [FP32_W-1:0] o_add_b,
    input  logic              i_add_rdy,
    input  logic              i_add_tago,
    input  logic [FP32_W-1:0] i_add_r,
    output logic [FP32_W-1:0] o_sum,
    output logic              o_sval,
    output logic [CNT_W-1:0]  o_cnt,
    output logic              o_err,
    output logic              o_busy
);

    // Watchdog must outlast the adder latency; clamp if misconfigured
    localparam int unsigned WD_LIMIT = (WD_CYCLES > ADD_LAT) ? WD_CYCLES : ADD_LAT + 1;

    state_t           r_state;
    fp32_t            r_acc;
    fp32_t            r_add_a;
    fp32_t            r_add_b;
    fp32_t            r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_cnt_out;
    logic             r_last;
    logic             r_etag;
    logic             r_add_act;
    logic             r_add_tag;
    logic             r_sval;
    logic             r_err;

    logic w_wait;
    logic w_accept;
    logic w_match;
    logic w_wd_pre;
    logic w_wd_exp;
    logic w_expire;
    logic w_kill;
    logic w_wd_clr;
    logic w_err_set;

    assign w_wait    = (r_state == WAIT);
    assign o_drdy    = ~i_reset & ~i_abort & (r_state == IDLE);
    assign w_accept  = i_dval & o_drdy;
    assign w_match   = w_wait & i_add_rdy & (i_add_tago == r_etag);
    assign w_expire  = w_wait & w_wd_exp;
    assign w_kill    = i_abort | w_expire;
    assign w_wd_clr  = ~w_wait | w_kill | w_match;
    // ERR is raised one cycle early so it lands on the expiry cycle itself
    assign w_err_set = w_wait & w_wd_pre & ~w_match & ~i_abort;

    fp32_accum_wd #(
        .LIMIT(WD_LIMIT)
    ) u_wd (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clr      (w_wd_clr),
        .i_en       (w_wait),
        .o_pre_c    (w_wd_pre),
        .o_expire_c (w_wd_exp)
    );

    // Issue/wait sequencer with accumulator, tag tracking and result capture
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_acc     <= fp32_t'(FP32_PZERO);
            r_add_a   <= fp32_t'(FP32_PZERO);
            r_add_b   <= fp32_t'(FP32_PZERO);
            r_sum     <= fp32_t'(FP32_PZERO);
            r_cnt     <= '0;
            r_cnt_out <= '0;
            r_last    <= 1'b0;
            r_etag    <= 1'b0;
            r_add_act <= 1'b0;
            r_add_tag <= 1'b0;
            r_sval    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_add_act <= 1'b0;
            r_sval    <= 1'b0;
            r_err     <= w_err_set;
            if (w_kill) begin
                r_state <= IDLE;
                r_acc   <= fp32_t'(FP32_PZERO);
                r_cnt   <= '0;
                r_last  <= 1'b0;
                r_etag  <= ~r_etag;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_accept) begin
                            r_add_a   <= r_acc;
                            r_add_b   <= fp32_t'(i_din);
                            r_add_tag <= r_etag;
                            r_add_act <= 1'b1;
                            r_last    <= i_dlast;
                            r_cnt     <= (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
                            r_state   <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (w_match) begin
                            r_etag  <= ~r_etag;
                            r_state <= IDLE;
                            if (r_last) begin
                                r_sum     <= fp32_t'(i_add_r);
                                r_cnt_out <= r_cnt;
                                r_sval    <= 1'b1;
                                r_acc     <= fp32_t'(FP32_PZERO);
                                r_cnt     <= '0;
                                r_last    <= 1'b0;
                            end else begin
                                r_acc <= fp32_t'(i_add_r);
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign o_add_act = r_add_act;
    assign o_add_tag = r_add_tag;
    assign o_add_a   = r_add_a;
    assign o_add_b   = r_add_b;
    assign o_sum     = r_sum;
    assign o_sval    = r_sval;
    assign o_cnt     = r_cnt_out;
    assign o_err     = r_err;
    assign o_busy    = (r_state != IDLE);

endmodule

// File: tb/tb_fp32_accum_seq.sv
// Bench for fp32_accum_seq with a behavioural 2-cycle tagged FP32 adder.
module tb_fp32_accum_seq;

    localparam int unsigned WD = 15;

    logic        clk = 1'b0;
    logic        rst, dval, dlast, abort;
    logic [31:0] din;
    logic        drdy, add_act, add_tag, add_rdy, add_tago, sval, err, busy;
    logic [31:0] add_a, add_b, add_r, sum;
    logic [15:0] cnt;

    int checks = 0;
    int errors = 0;
    int sval_seen = 0;
    int err_seen = 0;
    int both_seen = 0;
    int exp_vec = 0;
    int mode = 0;   // adder: 0 normal, 1 never answers, 2 answers with wrong tag

    always #5 clk = ~clk;

    fp32_accum_seq dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_dval     (dval),
        .i_din      (din),
        .i_dlast    (dlast),
        .o_drdy     (drdy),
        .i_abort    (abort),
        .o_add_act  (add_act),
        .o_add_tag  (add_tag),
        .o_add_a    (add_a),
        .o_add_b    (add_b),
        .i_add_rdy  (add_rdy),
        .i_add_tago (add_tago),
        .i_add_r    (add_r),
        .o_sum      (sum),
        .o_sval     (sval),
        .o_cnt      (cnt),
        .o_err      (err),
        .o_busy     (busy)
    );

    // FP32 <-> real conversions (normals, zero, Inf/NaN only)
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'h00)      d = {f[31], 63'h0};
        else if (f[30:23] == 8'hFF) d = {f[31], 11'h7FF, f[22:0], 29'h0};
        else                        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'h0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        e = d[62:52];
        if (e == 11'h000) return {d[63], 31'h0};
        if (e == 11'h7FF) return {d[63], 8'hFF, d[51:29]};
        return {d[63], 8'(e - 11'd896), d[51:29]};
    endfunction

    // Behavioural adder core: result and tag appear two cycles after ACT
    logic        s1_v, s1_t, s2_v, s2_t;
    logic [31:0] s1_r, s2_r;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            s1_v <= add_act && (mode != 1);
            s1_t <= add_tag ^ (mode == 2);
            s1_r <= r2f(f2r(add_a) + f2r(add_b));
            s2_v <= s1_v;
            s2_t <= s1_t;
            s2_r <= s1_r;
        end
    end
    assign add_rdy  = s2_v;
    assign add_tago = s2_t;
    assign add_r    = s2_r;

    // Pulse monitors sampled mid-cycle
    always @(negedge clk) begin
        if (sval) sval_seen <= sval_seen + 1;
        if (err) err_seen <= err_seen + 1;
        if (sval && err) both_seen <= both_seen + 1;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one element, wait (bounded) for acceptance; returns in the ACT cycle
    task automatic send_elem(input logic [31:0] v, input logic last, output int waited);
        dval = 1'b1; din = v; dlast = last;
        #1;
        waited = 0;
        while (!drdy && waited < 40) begin
            tick();
            waited++;
            #1;
        end
        if (!drdy) chk("accept_timeout", 32'(waited), 32'd0);
        tick();
        dval = 1'b0; dlast = 1'b0;
    endtask

    // Called in the ACT cycle after the last accept; checks latency, result, pulse width
    task automatic wait_sval(input string tag, input logic [31:0] esum, input int ecnt);
        int k;
        k = 1;
        while (!sval && k < 30) begin
            tick();
            k++;
        end
        chk({tag, "_latency"}, 32'(k), 32'd4);
        chk({tag, "_sum"}, sum, esum);
        chk({tag, "_cnt"}, 32'(cnt), 32'(ecnt));
        exp_vec++;
        tick();
        chk({tag, "_sval_pulse"}, 32'(sval), 32'd0);
    endtask

    initial begin
        int w, k, len, s, val, gap;
        rst = 1'b1; dval = 1'b0; din = '0; dlast = 1'b0; abort = 1'b0;

        // reset
        tick(); #1;
        chk("drdy_during_reset", 32'(drdy), 32'd0);
        tick(); rst = 1'b0; #1;
        chk("rst_sum", sum, 32'h0);
        chk("rst_sval", 32'(sval), 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_act", 32'(add_act), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drdy", 32'(drdy), 32'd1);

        // 1+2+3+4 = 10
        send_elem(32'h3F800000, 1'b0, w);
        send_elem(32'h40000000, 1'b0, w); chk("vec4_drdy_gap2", 32'(w), 32'd3);
        send_elem(32'h40400000, 1'b0, w); chk("vec4_drdy_gap3", 32'(w), 32'd3);
        send_elem(32'h40800000, 1'b1, w); chk("vec4_drdy_gap4", 32'(w), 32'd3);
        wait_sval("vec4", 32'h41200000, 4);

        // single element -5.0
        send_elem(32'hC0A00000, 1'b1, w);
        chk("single_act", 32'(add_act), 32'd1);
        chk("single_add_a", add_a, 32'h0);
        chk("single_add_b", add_b, 32'hC0A00000);
        wait_sval("single", 32'hC0A00000, 1);

        // abort the cycle after ACT of element 2, then a fresh 1.0 vector
        send_elem(32'h40000000, 1'b0, w);
        send_elem(32'h40400000, 1'b0, w);
        chk("abort_act_e2", 32'(add_act), 32'd1);
        tick();
        abort = 1'b1; dval = 1'b1; din = 32'h41000000; dlast = 1'b1; #1;
        chk("abort_drdy", 32'(drdy), 32'd0);
        tick();
        abort = 1'b0; dval = 1'b0; dlast = 1'b0; #1;
        chk("abort_busy", 32'(busy), 32'd0);
        send_elem(32'h3F800000, 1'b1, w);
        wait_sval("after_abort", 32'h3F800000, 1);

        // watchdog: adder silent, then adder answering with a stale tag
        for (int m = 1; m <= 2; m++) begin
            mode = m;
            send_elem(32'h40800000, 1'b0, w);
            k = 0;
            while (!err && k < 40) begin
                tick();
                k++;
            end
            chk("wd_err_delay", 32'(k), 32'(WD));
            chk("wd_busy_at_err", 32'(busy), 32'd1);
            tick();
            chk("wd_err_pulse", 32'(err), 32'd0);
            chk("wd_busy_after", 32'(busy), 32'd0);
            mode = 0;
            send_elem(32'h3F800000, 1'b1, w);
            wait_sval("wd_recover", 32'h3F800000, 1);
        end

        // reset for one cycle while waiting on the adder
        send_elem(32'h40000000, 1'b0, w);
        tick();
        rst = 1'b1; #1;
        chk("midrst_drdy", 32'(drdy), 32'd0);
        tick();
        rst = 1'b0; #1;
        chk("midrst_sum", sum, 32'h0);
        chk("midrst_sval", 32'(sval), 32'd0);
        chk("midrst_cnt", 32'(cnt), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        chk("midrst_act", 32'(add_act), 32'd0);
        chk("midrst_tag", 32'(add_tag), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_drdy_after", 32'(drdy), 32'd1);
        send_elem(32'h40000000, 1'b1, w);
        wait_sval("post_reset", 32'h40000000, 1);

        // +Inf propagates
        send_elem(32'h7F800000, 1'b0, w);
        send_elem(32'h3F800000, 1'b1, w);
        wait_sval("inf", 32'h7F800000, 2);

        // random integer-valued vectors against an exact reference sum
        for (int v = 0; v < 8; v++) begin
            len = int'($urandom_range(5, 1));
            s = 0;
            for (int i = 0; i < len; i++) begin
                val = int'($urandom_range(100, 0)) - 50;
                s += val;
                gap = int'($urandom_range(2, 0));
                for (int g = 0; g < gap; g++) tick();
                send_elem(r2f(real'(val)), (i == len - 1), w);
            end
            wait_sval("rand", r2f(real'(s)), len);
        end

        tick();
        chk("sval_total", 32'(sval_seen), 32'(exp_vec));
        chk("err_total", 32'(err_seen), 32'd2);
        chk("sval_err_overlap", 32'(both_seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
